cap_sensor_scanner: RTL

Produces the 288-bit `sensor_readings` bus consumed by the processor memory stage: nine 32-bit slots, one per capacitive pad.
- Scans the pads sequentially using the RC charge-time method:
  - discharge the pad (drive low);
  - release it (external pull-up charges it);
  - count clock cycles until the synchronized pad input reads high.
- Stores the count per pad, derives a per-pad touched flag, and pulses `scan_done` after each full sweep.
- Sits at the FPGA top level between the pad I/O buffers and the processor.

---
 rtl/cap_sensor_pkg.sv | 19 +
 rtl/pad_synchronizer.sv | 24 ++
 rtl/cap_sensor_scanner.sv | 100 ++++++++++
 3 files changed

// File: rtl/cap_sensor_pkg.sv
// Shared constants for the capacitive pad scanner and the memory stage that consumes its readings bus.
// The state encoding is kept as plain localparams so older consumers can decode it.
package cap_sensor_pkg;

  localparam int NUM_PADS   = 9;
  localparam int SLOT_W     = 32;
  localparam int READINGS_W = NUM_PADS * SLOT_W;
  localparam int CNT_W      = 16;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DISCHARGE = 2'd1;
  localparam logic [1:0] MEASURE   = 2'd2;
  localparam logic [1:0] STORE     = 2'd3;

  function automatic logic [SLOT_W-1:0] zext_cnt(input logic [CNT_W-1:0] cnt);
    return {{(SLOT_W-CNT_W){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/pad_synchronizer.sv
// Purpose: two-flop synchronizer for raw asynchronous pad levels.
// Latency: 2 cycles. Backpressure: none, free-running.
module pad_synchronizer #(
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/cap_sensor_scanner.sv
// Purpose: sequential RC charge-time scan of nine pads into a 288-bit readings bus.
// Latency: one sweep = sum over pads of (DISCHARGE_CYCLES + count + 2). Backpressure: none.
module cap_sensor_scanner
  import cap_sensor_pkg::*;
#(
  parameter int unsigned DISCHARGE_CYCLES = 50,
  parameter int unsigned TIMEOUT          = 65535,
  parameter int unsigned TOUCH_THRESHOLD  = 200
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_PADS-1:0]   pad_in,
  output logic [NUM_PADS-1:0]   pad_drive_low,
  output logic [READINGS_W-1:0] sensor_readings,
  output logic [NUM_PADS-1:0]   touched,
  output logic                  scan_done
);

  localparam logic [CNT_W-1:0] DIS_LAST  = CNT_W'(DISCHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOUCH_THR = CNT_W'(TOUCH_THRESHOLD);
  localparam logic [3:0]       LAST_IDX  = 4'(NUM_PADS - 1);

  logic [1:0]                       state;
  logic [3:0]                       idx;
  logic [CNT_W-1:0]                 dis_cnt;
  logic [CNT_W-1:0]                 meas_cnt;
  logic [CNT_W-1:0]                 meas_val;
  logic [NUM_PADS-1:0]              pad_sync;
  logic [NUM_PADS-1:0][SLOT_W-1:0]  readings_q;

  pad_synchronizer #(.WIDTH(NUM_PADS)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (pad_in),
    .q     (pad_sync)
  );

  assign sensor_readings = readings_q;
  assign scan_done       = (state == STORE) && (idx == LAST_IDX);

  // Only the pad under measurement is released; every other pad stays grounded.
  always_comb begin
    pad_drive_low = '1;
    if (state == MEASURE) pad_drive_low[idx] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      dis_cnt    <= '0;
      meas_cnt   <= '0;
      meas_val   <= '0;
      readings_q <= '0;
      touched    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state   <= DISCHARGE;
            idx     <= '0;
            dis_cnt <= '0;
          end
        end
        DISCHARGE: begin
          dis_cnt <= dis_cnt + 1'b1;
          if (dis_cnt == DIS_LAST) begin
            state    <= MEASURE;
            meas_cnt <= '0;
          end
        end
        MEASURE: begin
          // Saturate at the timeout so a missing pad never wraps to a small count.
          if (pad_sync[idx] || (meas_cnt == CNT_SAT)) begin
            meas_val <= meas_cnt;
            state    <= STORE;
          end else begin
            meas_cnt <= meas_cnt + 1'b1;
          end
        end
        STORE: begin
          readings_q[idx] <= zext_cnt(meas_val);
          touched[idx]    <= (meas_val >= TOUCH_THR);
          dis_cnt         <= '0;
          if (idx == LAST_IDX) begin
            idx   <= '0;
            state <= IDLE;
          end else begin
            idx   <= idx + 1'b1;
            state <= DISCHARGE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
